// File: rtl/systolic_feeder.sv
// Purpose : operand feeder for a DIM x DIM systolic multiply array; latches A and B,
//           clears the array, then streams diagonally skewed rows of A / columns of B.
// Latency : start to done_o is 3*DIM-1 cycles; one run every 3*DIM+1 cycles at most.
// Backpr. : none; start_i is a request honoured only in IDLE, and is dropped (not queued) otherwise.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    run request, sampled only while idle
//   a_i        matrix A, A[r][k] at bits (r*DIM+k)*DATA_WIDTH
//   b_i        matrix B, B[k][c] at bits (k*DIM+c)*DATA_WIDTH
//   left_o     left-edge operands, row r at r*DATA_WIDTH (to PE(r,0))
//   up_o       top-edge operands, column c at c*DATA_WIDTH (to PE(0,c))
//   pe_rst_no  active-low clear for the PE array
//   busy_o     high while clearing or feeding
//   done_o     one-cycle pulse: array accumulators hold the final product

module systolic_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]   a_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]   b_i,
  output logic [DIM*DATA_WIDTH-1:0]       left_o,
  output logic [DIM*DATA_WIDTH-1:0]       up_o,
  output logic                            pe_rst_no,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int MAT_W  = DIM * DIM * DATA_WIDTH;
  localparam int EDGE_W = DIM * DATA_WIDTH;
  // Last feed step: the final product pair meets in PE(DIM-1,DIM-1) here.
  localparam int LAST_T = 3 * DIM - 3;
  localparam int CNT_W  = $clog2(3 * DIM - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic [MAT_W-1:0]   a_q, a_d;
  logic [MAT_W-1:0]   b_q, b_d;

  logic [EDGE_W-1:0]  left_q, left_d;
  logic [EDGE_W-1:0]  up_q, up_d;
  logic               pe_rst_n_q, pe_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      IDLE: begin
        // The operands are captured once here; later input changes are
        // invisible to the running job.
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end

      FEED: begin
        if (t_q == CNT_W'(LAST_T)) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  //
  // Outputs are registered, so they are decoded from the *next* state and
  // step. That way the edge that enters FEED with t=0 already presents the
  // t=0 operands, and the edge that leaves FEED already zeroes the edges.
  // The operand registers are read directly: they were loaded on the edge
  // that entered CLEAR, so they are stable whenever FEED is the next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    left_d     = '0;
    up_d       = '0;
    pe_rst_n_d = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_d)
      CLEAR: begin
        pe_rst_n_d = 1'b0;
        busy_d     = 1'b1;
      end

      FEED: begin
        busy_d = 1'b1;
        // Row r of the left edge carries A[r][k] at step t = r + k; the r-cycle
        // delay lines up with the column skew inside the array.
        for (int r = 0; r < DIM; r++) begin
          for (int k = 0; k < DIM; k++) begin
            if (int'(t_d) == r + k) begin
              left_d[r*DATA_WIDTH +: DATA_WIDTH] = a_q[(r*DIM + k)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        // Column c of the top edge carries B[k][c] at step t = k + c.
        for (int c = 0; c < DIM; c++) begin
          for (int k = 0; k < DIM; k++) begin
            if (int'(t_d) == k + c) begin
              up_d[c*DATA_WIDTH +: DATA_WIDTH] = b_q[(k*DIM + c)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end

      DONE: begin
        done_d = 1'b1;
      end

      default: begin
        // IDLE: edges quiet so the array holds its results.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  //
  // pe_rst_no resets low so the array is held cleared for as long as this
  // block is in reset, including a mid-run abort.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      t_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      left_q     <= '0;
      up_q       <= '0;
      pe_rst_n_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_q        <= a_d;
      b_q        <= b_d;
      left_q     <= left_d;
      up_q       <= up_d;
      pe_rst_n_q <= pe_rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign left_o    = left_q;
  assign up_o      = up_q;
  assign pe_rst_no = pe_rst_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a DIM=2 instance driven from a cycle table and
// feeding a small behavioural PE array, plus a DIM=4 instance for latency,
// ignored-start, input-change and mid-run reset sequences.

module tb_systolic_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DIM=2 instance ----------------
  logic         rst2_n, start2;
  logic [127:0] a2, b2;
  logic [63:0]  left2, up2;
  logic         pern2, busy2, done2;

  systolic_feeder #(.DATA_WIDTH(32), .DIM(2)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .start_i(start2), .a_i(a2), .b_i(b2),
    .left_o(left2), .up_o(up2), .pe_rst_no(pern2), .busy_o(busy2), .done_o(done2)
  );

  // Behavioural 2x2 output-stationary PE array: operands move right / down one
  // PE per cycle, each PE accumulates left*up, cleared while pe_rst_no is low.
  logic [31:0] pa [2][2];
  logic [31:0] pb [2][2];
  logic [31:0] acc[2][2];

  always @(posedge clk) begin
    if (!pern2) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          pa[r][c]  <= '0;
          pb[r][c]  <= '0;
          acc[r][c] <= '0;
        end
    end else begin
      pa[0][0] <= left2[31:0];   pa[0][1] <= pa[0][0];
      pa[1][0] <= left2[63:32];  pa[1][1] <= pa[1][0];
      pb[0][0] <= up2[31:0];     pb[1][0] <= pb[0][0];
      pb[0][1] <= up2[63:32];    pb[1][1] <= pb[0][1];
      acc[0][0] <= acc[0][0] + left2[31:0]  * up2[31:0];
      acc[0][1] <= acc[0][1] + pa[0][0]     * up2[63:32];
      acc[1][0] <= acc[1][0] + left2[63:32] * pb[0][0];
      acc[1][1] <= acc[1][1] + pa[1][0]     * pb[0][1];
    end
  end

  // ---------------- DIM=4 instance ----------------
  logic         rst4_n, start4;
  logic [511:0] a4, b4;
  logic [127:0] left4, up4;
  logic         pern4, busy4, done4;

  systolic_feeder #(.DATA_WIDTH(32), .DIM(4)) dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .start_i(start4), .a_i(a4), .b_i(b4),
    .left_o(left4), .up_o(up4), .pe_rst_no(pern4), .busy_o(busy4), .done_o(done4)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected DIM=4 edge at step t from the skew rule.
  function automatic logic [127:0] exp_edge(input logic [511:0] m, input int t, input bit is_left);
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        if (t == i + k)
          res[i*32 +: 32] = is_left ? m[(i*4 + k)*32 +: 32] : m[(k*4 + i)*32 +: 32];
    return res;
  endfunction

  // One full DIM=4 run with cycle-by-cycle stream checks. With noisy=1, start
  // stays high and the operand inputs keep changing during the run.
  task automatic run4(input logic [511:0] ma, input logic [511:0] mb, input bit noisy, input string tag);
    int dcnt;
    a4 = ma; b4 = mb; start4 = 1'b1;
    @(posedge clk); #1;
    chk({tag, " clear"}, {253'd0, pern4, busy4, done4}, {253'd0, 1'b0, 1'b1, 1'b0});
    if (!noisy) start4 = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      if (noisy) begin
        a4 = ~a4;
        b4 = b4 + 512'd1;
      end
      @(posedge clk); #1;
      chk($sformatf("%s left t=%0d", tag, t), {128'd0, left4}, {128'd0, exp_edge(ma, t, 1'b1)});
      chk($sformatf("%s up t=%0d", tag, t), {128'd0, up4}, {128'd0, exp_edge(mb, t, 1'b0)});
    end
    @(posedge clk); #1;
    chk({tag, " done"}, {253'd0, done4, busy4, 1'b0}, {253'd0, 1'b1, 1'b0, 1'b0});
    start4 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) dcnt++;
    end
    chk({tag, " quiet after done"}, 256'(dcnt), 256'd0);
  endtask

  // ---------------- DIM=2 cycle table ----------------
  typedef struct packed {
    logic         start;
    logic [127:0] a;
    logic [127:0] b;
    logic [63:0]  left;
    logic [63:0]  up;
    logic         pern;
    logic         busy;
    logic         done;
    logic [127:0] acc;   // {acc11, acc10, acc01, acc00}, checked when done
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(input logic s, input logic [127:0] a, input logic [127:0] b,
                              input logic [63:0] l, input logic [63:0] u,
                              input logic p, input logic bz, input logic d, input logic [127:0] ac);
    vec_t v;
    v.start = s; v.a = a; v.b = b; v.left = l; v.up = u;
    v.pern = p; v.busy = bz; v.done = d; v.acc = ac;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [127:0] ma1, mb, ma2, junk;
    logic [511:0] m4a, m4b;
    int n, bcnt, dcnt;

    ma1  = {32'd4, 32'd3, 32'd2, 32'd1};   // A = [[1,2],[3,4]]
    mb   = {32'd8, 32'd7, 32'd6, 32'd5};   // B = [[5,6],[7,8]]
    ma2  = {32'd1, 32'd0, 32'd0, 32'd1};   // A = I
    junk = {4{32'hdead_beef}};

    // Edges listed {hi, lo}: left {row1,row0}, up {col1,col0}.
    vec[0]  = mk(1, ma1,  mb,   64'd0,                   64'd0,                   0, 1, 0, '0);
    vec[1]  = mk(0, junk, junk, {32'd0, 32'd1},          {32'd0, 32'd5},          1, 1, 0, '0);
    vec[2]  = mk(0, junk, junk, {32'd3, 32'd2},          {32'd6, 32'd7},          1, 1, 0, '0);
    vec[3]  = mk(0, junk, junk, {32'd4, 32'd0},          {32'd8, 32'd0},          1, 1, 0, '0);
    vec[4]  = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 1, 0, '0);
    vec[5]  = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 0, 1,
                 {32'd50, 32'd43, 32'd22, 32'd19});
    vec[6]  = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 0, 0, '0);
    vec[7]  = mk(1, ma2,  mb,   64'd0,                   64'd0,                   0, 1, 0, '0);
    vec[8]  = mk(0, junk, junk, {32'd0, 32'd1},          {32'd0, 32'd5},          1, 1, 0, '0);
    vec[9]  = mk(0, junk, junk, 64'd0,                   {32'd6, 32'd7},          1, 1, 0, '0);
    vec[10] = mk(0, junk, junk, {32'd1, 32'd0},          {32'd8, 32'd0},          1, 1, 0, '0);
    vec[11] = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 1, 0, '0);
    vec[12] = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 0, 1,
                 {32'd8, 32'd7, 32'd6, 32'd5});
    vec[13] = mk(0, junk, junk, 64'd0,                   64'd0,                   1, 0, 0, '0);

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        m4a[(r*4 + k)*32 +: 32] = 32'(r*10 + k + 1);
        m4b[(r*4 + k)*32 +: 32] = 32'(100 + r*10 + k);
      end

    // ---------------- reset and idle ----------------
    rst2_n = 1'b0; rst4_n = 1'b0;
    start2 = 1'b0; start4 = 1'b0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs d2", {126'd0, left2, up2, pern2, busy2, done2}, 256'd0);
    chk("reset outputs d4", {253'd0, pern4, busy4, done4}, 256'd0);
    rst2_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after release d2", {126'd0, left2, up2, pern2, busy2, done2}, {255'd0, 1'b1} << 2);
    chk("idle after release d4", {125'd0, left4, pern4, busy4, done4}, {255'd0, 1'b1} << 2);
    #2 rst2_n = 1'b0;
    #1 chk("async reset pe_rst_no", {255'd0, pern2}, 256'd0);
    #1 rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("pe_rst_no back high", {253'd0, pern2, busy2, done2}, {253'd0, 1'b1, 1'b0, 1'b0});

    // ---------------- DIM=2 table, two back-to-back runs ----------------
    for (int i = 0; i < 14; i++) begin
      start2 = vec[i].start;
      a2     = vec[i].a;
      b2     = vec[i].b;
      @(posedge clk); #1;
      chk($sformatf("d2 vec %0d edges/flags", i),
          {125'd0, left2, up2, pern2, busy2, done2},
          {125'd0, vec[i].left, vec[i].up, vec[i].pern, vec[i].busy, vec[i].done});
      if (vec[i].done)
        chk($sformatf("d2 vec %0d products", i),
            {128'd0, acc[1][1], acc[1][0], acc[0][1], acc[0][0]}, {128'd0, vec[i].acc});
    end
    start2 = 1'b0;

    // ---------------- DIM=4 latency and busy length ----------------
    a4 = m4a; b4 = m4b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    bcnt = busy4 ? 1 : 0;
    n = 41;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (busy4) bcnt++;
      if (done4) begin
        n = e;
        break;
      end
    end
    chk("d4 start-to-done edges", 256'(n), 256'd11);
    chk("d4 busy cycles", 256'(bcnt), 256'd11);
    @(posedge clk); #1;
    chk("d4 idle after done", {253'd0, busy4, done4, 1'b0}, 256'd0);

    // ---------------- DIM=4 streams: clean, then noisy inputs ----------------
    run4(m4a, m4b, 1'b0, "d4 clean");
    run4(m4b, m4a, 1'b1, "d4 noisy");

    // ---------------- DIM=4 reset mid-FEED at t=3 ----------------
    a4 = m4a; b4 = m4b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("d4 left at t=3 before abort", {128'd0, left4}, {128'd0, exp_edge(m4a, 3, 1'b1)});
    #2 rst4_n = 1'b0;
    #1 chk("d4 abort outputs", {3'd0, left4, up4, pern4, busy4, done4}, 256'd0);
    #2 rst4_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) dcnt++;
    end
    chk("d4 no activity after abort", 256'(dcnt), 256'd0);
    chk("d4 pe_rst_no high after abort", {255'd0, pern4}, 256'd1);
    run4(m4a, m4b, 1'b0, "d4 after abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
